// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, sizes and row-priority helper for the keypad scanner.
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, RELEASE} state_e;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W = 4;
  function automatic logic [1:0] first_low(input logic [NUM_ROWS-1:0] rows);
    return !rows[0] ? 2'd0 : !rows[1] ? 2'd1 : !rows[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: 2-flop synchroniser; resets to all-ones so idle rows read released.
module keypad_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q, sync_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  assign q_o = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad, debounces press and release,
// and emits one enter strobe with the key code per accepted press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_sense,
  output logic [NUM_COLS-1:0] col_drive,
  output logic [KEY_W-1:0]    digit,
  output logic                enter
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  state_e state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] col_q, col_d, row_q, row_d;
  logic [KEY_W-1:0] digit_q, digit_d;
  logic enter_q, enter_d;
  logic [NUM_ROWS-1:0] row_s;
  keypad_sync #(.W(NUM_ROWS)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (row_sense),
    .q_o  (row_s)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= SCAN;
      dwell_q <= '0;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      digit_q <= '0;
      enter_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      digit_q <= digit_d;
      enter_q <= enter_d;
    end
  // col_q stays put through DEBOUNCE and RELEASE, which freezes col_drive.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    digit_d = digit_q;
    enter_d = 1'b0;
    case (state_q)
      SCAN:
        if (dwell_q != DWELL_MAX) dwell_d = dwell_q + 1'b1;
        else if (!(&row_s)) begin
          row_d   = first_low(row_s);
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end else begin
          col_d   = col_q + 2'd1;
          dwell_d = '0;
        end
      DEBOUNCE:
        if (row_s[row_q]) begin
          col_d   = col_q + 2'd1;
          dwell_d = '0;
          state_d = SCAN;
        end else if (cnt_q == CNT_MAX) begin
          enter_d = 1'b1;
          digit_d = {row_q, col_q};
          cnt_d   = '0;
          state_d = RELEASE;
        end else cnt_d = cnt_q + 1'b1;
      RELEASE:
        if (!(&row_s)) cnt_d = '0;
        else if (cnt_q == CNT_MAX) begin
          col_d   = col_q + 2'd1;
          dwell_d = '0;
          cnt_d   = '0;
          state_d = SCAN;
        end else cnt_d = cnt_q + 1'b1;
      default: state_d = SCAN;
    endcase
  end
  assign col_drive = ~(NUM_COLS'(1) << col_q);
  assign digit = digit_q;
  assign enter = enter_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model plus expected-key queue checking strobes,
// held digit, scan cadence, latency bounds and reset behaviour.
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DB = 8;
  localparam int LAT_MIN = 2 + DB + 1;
  localparam int LAT_MAX = LAT_MIN + 4 * SD;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] row_sense, col_drive, digit;
  logic enter;
  logic [15:0] keys = '0;
  logic [3:0] model_digit = '0;
  int n_assert = 0;
  int n_fail = 0;
  int n_pulse = 0;
  int exp_q[$];
  always #5 clk = ~clk;
  always_comb
    for (int r = 0; r < 4; r++) row_sense[r] = ~|(keys[4*r +: 4] & ~col_drive);
  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk      (clk),
    .reset    (reset),
    .row_sense(row_sense),
    .col_drive(col_drive),
    .digit    (digit),
    .enter    (enter)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_strobe();
    int lat;
    lat = 0;
    while (enter !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("strobe_latency", (lat >= LAT_MIN && lat <= LAT_MAX), 1);
  endtask
  task automatic key_down(input int r, input int c);
    keys[4*r+c] = 1'b1;
    exp_q.push_back(4 * r + c);
    wait_strobe();
  endtask
  task automatic press(input int r, input int c, input int hold, input int gap);
    key_down(r, c);
    cyc(hold);
    keys = '0;
    cyc(gap);
  endtask
  task automatic next_col(output int n, output logic [3:0] prev);
    prev = col_drive;
    n = 0;
    while (col_drive === prev && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask
  initial begin
    int n, p0, r, c;
    logic [3:0] prev;
    int seq_r[4] = '{1, 0, 0, 0};
    int seq_c[4] = '{0, 1, 3, 2};
    fork
      forever begin
        @(negedge clk);
        if (reset) begin
          model_digit = '0;
          chk("rst_enter", enter, 0);
          chk("rst_digit", digit, 0);
          chk("rst_col", col_drive, 4'hE);
        end else begin
          if (enter) begin
            n_pulse++;
            chk("strobe_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) model_digit = 4'(exp_q.pop_front());
            chk("strobe_digit", digit, model_digit);
          end else chk("digit_hold", digit, model_digit);
          chk("col_onehot0", $countones(~col_drive), 1);
        end
      end
    join_none
    cyc(3);
    reset = 1'b0;
    next_col(n, prev);
    for (int i = 0; i < 5; i++) begin
      next_col(n, prev);
      chk("scan_period", n, SD);
      chk("scan_next", col_drive, {prev[2:0], prev[3]});
    end
    while (col_drive !== 4'hE) @(negedge clk);
    p0 = n_pulse;
    key_down(1, 0);
    cyc(180);
    chk("hold_frozen", col_drive, 4'hE);
    chk("hold_one_pulse", n_pulse - p0, 1);
    keys = '0;
    next_col(n, prev);
    chk("resume_bound", n < 40, 1);
    chk("resume_col1", col_drive, 4'hD);
    cyc(2);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_col", col_drive, 4'hE);
    chk("async_rst_enter", enter, 0);
    chk("async_rst_digit", digit, 0);
    cyc(2);
    reset = 1'b0;
    p0 = n_pulse;
    repeat (5) begin
      keys[11] = 1'b1;
      cyc(3);
      keys[11] = 1'b0;
      cyc(2);
    end
    cyc(60);
    chk("bounce_no_strobe", n_pulse - p0, 0);
    p0 = n_pulse;
    for (int i = 0; i < 4; i++) press(seq_r[i], seq_c[i], 50, 50);
    chk("seq_count", n_pulse - p0, 4);
    p0 = n_pulse;
    keys[12] = 1'b1;
    key_down(2, 0);
    cyc(30);
    keys[8] = 1'b0;
    cyc(60);
    chk("multi_one_pulse", n_pulse - p0, 1);
    chk("multi_held_frozen", col_drive, 4'hE);
    keys = '0;
    cyc(60);
    chk("multi_no_repeat", n_pulse - p0, 1);
    reset = 1'b1;
    cyc(2);
    keys[0] = 1'b1;
    reset = 1'b0;
    cyc(9);
    p0 = n_pulse;
    reset = 1'b1;
    #1;
    chk("dbnc_rst_col", col_drive, 4'hE);
    chk("dbnc_rst_enter", enter, 0);
    cyc(3);
    reset = 1'b0;
    chk("dbnc_rst_no_strobe", n_pulse - p0, 0);
    exp_q.push_back(0);
    wait_strobe();
    cyc(20);
    keys = '0;
    cyc(40);
    chk("dbnc_rst_one_pulse", n_pulse - p0, 1);
    p0 = n_pulse;
    repeat (12) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      press(r, c, $urandom_range(40, 80), $urandom_range(30, 60));
    end
    chk("random_count", n_pulse - p0, 12);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad, synchronises and debounces the row inputs, and encodes each accepted key press as a 4-bit code. It drives the `digit`/`enter` entry interface of the door lock FSM. Each press produces exactly one single-cycle `enter` strobe with a stable `digit`. No auto-repeat is produced while a key is held.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column is driven. Must be ≥ 4.
- `DEBOUNCE_CYCLES`, default 200000: consecutive stable cycles required to accept a press, and likewise a release. Must be ≥ 2.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `row_sense`  in  4  keypad rows, active-low. Asynchronous to `clk`.
- `col_drive`  out  4  keypad columns, active-low, one-hot zero.
- `digit`  out  4  key code = 4*row + col. Held from the `enter` pulse until the next press.
- `enter`  out  1  one-cycle strobe; `digit` is valid in the same cycle.

## Operation
- Reset values:
  - `col_drive` = 4'b1110 (column 0 driven)
  - `digit` = 0
  - `enter` = 0
  - state SCAN
  - all counters 0
- `row_sense` passes through a 2-flop synchroniser to give `row_s`. All decisions use `row_s`.
- SCAN state:
  - A dwell counter counts 0..SCAN_DIV-1 per column.
  - At dwell = SCAN_DIV-1, the block samples `row_s`.
  - If any bit is 0: latch the lowest-index low row as `r` and the current column as `c`. Freeze `col_drive`, clear the debounce counter, and go to DEBOUNCE.
  - Otherwise: advance to the next column (3 wraps to 0) and clear dwell.
- DEBOUNCE state, evaluated each cycle:
  - If `row_s[r]` = 0: increment the counter. When the counter reaches DEBOUNCE_CYCLES-1, register `enter`=1 and `digit`={r[1:0],c[1:0]}, then go to RELEASE.
  - If `row_s[r]` = 1 (bounce or abort): no strobe. Return to SCAN at the next column with dwell cleared.
- RELEASE state:
  - Keep `col_drive` frozen.
  - The counter counts consecutive cycles with `row_s` = 4'b1111. Any low bit clears it.
  - At DEBOUNCE_CYCLES-1, return to SCAN at the next column.
- Multiple keys in one column: the lowest row index wins. Other keys are ignored until all rows are released.
- A second key pressed during RELEASE prevents release until it too is released. It never produces a strobe.
- `enter` is deasserted every cycle except the single strobe cycle.

## Timing
- Let edge E0 be the SCAN→DEBOUNCE transition.
  - `enter` is high for exactly the one cycle after edge E(DEBOUNCE_CYCLES), provided `row_s[r]` is low at every sample E1..E(DEBOUNCE_CYCLES).
  - The minimum press-to-strobe latency is therefore 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after the row is seen by the dwell sample.
- The synchroniser lag is 2 cycles. Sampling at the last dwell cycle with SCAN_DIV ≥ 4 guarantees `row_s` reflects the currently driven column.
- A full scan period is 4*SCAN_DIV cycles.
- Reset asserted mid-DEBOUNCE or mid-RELEASE aborts immediately: no strobe, outputs return to reset values.
- Reset released in the same cycle as a press: the press is detected on a later scan, never lost permanently.

## Structure
- Shared package `keypad_pkg` holds:
  - state enum {SCAN, DEBOUNCE, RELEASE}
  - `NUM_ROWS` = 4, `NUM_COLS` = 4
  - `KEY_W` = 4
- Sub-module `keypad_sync`: a parameterised-width 2-flop synchroniser with asynchronous reset to all-ones (idle rows).
- The top module contains the FSM, the dwell counter ($clog2(SCAN_DIV) bits) and the debounce counter ($clog2(DEBOUNCE_CYCLES) bits).

## Test plan
Simulation uses SCAN_DIV=4, DEBOUNCE_CYCLES=8. The keypad model pulls `row_sense[r]` low only while `col_drive[c]`=0.
- Reset: assert `reset` mid-scan → `col_drive`=1110, `enter`=0, `digit`=0 on the same cycle.
- Hold row1/col0 for 200 cycles, then release → exactly one `enter` pulse with `digit`=4, no repeat, scanning resumes at column 1.
- Row2/col3 bounces (low 3 cycles, high 2 cycles, repeated 5 times), then stays high → zero `enter` pulses.
- Press/release sequence (1,0), (0,1), (0,3), (0,2) as (row,col), each held 50 cycles with a 50-cycle gap → four strobes with `digit` = 4, 1, 3, 2; the door lock downstream asserts `unlock`.
- Rows 2 and 3 pressed together on col0 → single strobe with `digit`=8. Release row2 only → no further strobe until both are released.
- Assert `reset` at DEBOUNCE count 5 → no strobe, `col_drive`=1110. After reset is released, the still-held key yields one strobe.
